// File: rtl/scalefac_long_loader.sv
// Loads one granule of long-block scalefactors from the bit reader into the
// write side of a double buffer, then swaps the buffer once the consumer is done.
module scalefac_long_loader #(
  parameter int NUM_BANDS  = 22,
  parameter int SPLIT_BAND = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] slen1,
  input  logic [2:0] slen2,
  output logic       br_req,
  output logic [2:0] br_len,
  input  logic       br_valid,
  input  logic [3:0] br_data,
  input  logic       consumer_done,
  output logic       scalfac_write_enable,
  output logic [5:0] scalfac_write_addr,
  output logic [3:0] scalfac_write_data,
  output logic       buffer_switch_event,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, FILLED, SWITCH} state_t;

  state_t     r_state;
  logic [2:0] r_slen1;
  logic [2:0] r_slen2;
  logic [5:0] r_band;
  logic       r_pending;

  logic [2:0] w_slen;
  logic [2:0] w_width;
  logic [3:0] w_mask;
  logic       w_last;

  // The last band is never coded; widths above 4 saturate to the data bus width.
  always_comb begin
    w_slen  = (r_band < 6'(SPLIT_BAND)) ? r_slen1 : r_slen2;
    w_last  = (r_band == 6'(NUM_BANDS - 1));
    w_width = w_slen;
    if (w_last) begin
      w_width = 3'd0;
    end else if (w_slen > 3'd4) begin
      w_width = 3'd4;
    end
    w_mask = 4'((5'd1 << w_width) - 5'd1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state              <= IDLE;
      r_slen1              <= 3'd0;
      r_slen2              <= 3'd0;
      r_band               <= 6'd0;
      r_pending            <= 1'b1;
      br_req               <= 1'b0;
      br_len               <= 3'd0;
      scalfac_write_enable <= 1'b0;
      scalfac_write_addr   <= 6'd0;
      scalfac_write_data   <= 4'd0;
      buffer_switch_event  <= 1'b0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
    end else begin
      scalfac_write_enable <= 1'b0;
      buffer_switch_event  <= 1'b0;
      done                 <= 1'b0;
      if (consumer_done) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_slen1 <= slen1;
            r_slen2 <= slen2;
            r_band  <= 6'd0;
            busy    <= 1'b1;
            r_state <= LOAD;
          end
        end

        LOAD: begin
          if (w_width == 3'd0) begin
            scalfac_write_enable <= 1'b1;
            scalfac_write_addr   <= r_band;
            scalfac_write_data   <= 4'd0;
            if (w_last) begin
              r_state <= FILLED;
            end else begin
              r_band  <= r_band + 6'd1;
              r_state <= LOAD;
            end
          end else begin
            br_req  <= 1'b1;
            br_len  <= w_width;
            r_state <= WAIT;
          end
        end

        WAIT: begin
          if (br_valid) begin
            br_req               <= 1'b0;
            br_len               <= 3'd0;
            scalfac_write_enable <= 1'b1;
            scalfac_write_addr   <= r_band;
            scalfac_write_data   <= br_data & w_mask;
            if (w_last) begin
              r_state <= FILLED;
            end else begin
              r_band  <= r_band + 6'd1;
              r_state <= LOAD;
            end
          end
        end

        // A consumer_done seen earlier in the granule is remembered in r_pending.
        FILLED: begin
          if (r_pending || consumer_done) begin
            r_pending           <= 1'b0;
            buffer_switch_event <= 1'b1;
            done                <= 1'b1;
            r_state             <= SWITCH;
          end
        end

        SWITCH: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scalefac_long_loader.sv
// Randomized bench for scalefac_long_loader: a bit-reader responder feeds data,
// and each granule is checked against a per-band width/timing model.
module tb_scalefac_long_loader;

  localparam int NB    = 22;
  localparam int SPLIT = 11;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] slen1 = 3'd0;
  logic [2:0] slen2 = 3'd0;
  logic       br_valid = 1'b0;
  logic [3:0] br_data = 4'd0;
  logic       consumer_done = 1'b0;
  logic       br_req;
  logic [2:0] br_len;
  logic       scalfac_write_enable;
  logic [5:0] scalfac_write_addr;
  logic [3:0] scalfac_write_data;
  logic       buffer_switch_event;
  logic       busy;
  logic       done;

  scalefac_long_loader #(.NUM_BANDS(NB), .SPLIT_BAND(SPLIT)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .slen1                (slen1),
    .slen2                (slen2),
    .br_req               (br_req),
    .br_len               (br_len),
    .br_valid             (br_valid),
    .br_data              (br_data),
    .consumer_done        (consumer_done),
    .scalfac_write_enable (scalfac_write_enable),
    .scalfac_write_addr   (scalfac_write_addr),
    .scalfac_write_data   (scalfac_write_data),
    .buffer_switch_event  (buffer_switch_event),
    .busy                 (busy),
    .done                 (done)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; int cyc; } wr_t;
  typedef struct { int len; int data; int delay; bit stable; } rd_t;

  wr_t wrQ[$];
  rd_t rdQ[$];
  int  swQ[$];
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  int  fixedDelay = -1;
  int  fixedData = -1;
  int  longBand = -1;
  int  longDelay = 0;
  bit  noiseEn = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic int bandWidth(input int b, input int s1, input int s2);
    int s;
    if (b == NB - 1) return 0;
    s = (b < SPLIT) ? s1 : s2;
    return (s > 4) ? 4 : s;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor plus bit-reader responder; stray br_valid noise is injected while no request is open.
  initial begin : monitor
    int  waitCnt;
    int  curDelay;
    int  firstLen;
    bit  stable;
    bit  active;
    active = 1'b0;
    waitCnt = 0;
    curDelay = 0;
    firstLen = 0;
    stable = 1'b1;
    forever begin
      @(negedge clk);
      if (scalfac_write_enable === 1'b1)
        wrQ.push_back('{int'(scalfac_write_addr), int'(scalfac_write_data), cyc});
      if (buffer_switch_event === 1'b1) swQ.push_back(cyc);
      if (buffer_switch_event === 1'b1 || done === 1'b1)
        checkOutput("doneWithSwitch", done, buffer_switch_event);
      br_valid = 1'b0;
      br_data  = 4'd0;
      if (br_req === 1'b1) begin
        if (!active) begin
          active   = 1'b1;
          waitCnt  = 0;
          firstLen = int'(br_len);
          stable   = 1'b1;
          if (wrQ.size() == longBand) curDelay = longDelay;
          else if (fixedDelay >= 0)   curDelay = fixedDelay;
          else                        curDelay = $urandom_range(0, 3);
        end else if (int'(br_len) != firstLen) begin
          stable = 1'b0;
        end
        if (waitCnt == curDelay) begin
          br_valid = 1'b1;
          br_data  = (fixedData >= 0) ? 4'(fixedData) : 4'($urandom_range(0, 15));
          rdQ.push_back('{firstLen, int'(br_data), curDelay, stable});
        end
        waitCnt++;
      end else begin
        active = 1'b0;
        if (noiseEn && $urandom_range(0, 1) == 1) begin
          br_valid = 1'b1;
          br_data  = 4'($urandom_range(0, 15));
        end
      end
    end
  end

  task automatic checkResetOutputs();
    checkOutput("rstBrReq", br_req, 0);
    checkOutput("rstBrLen", br_len, 0);
    checkOutput("rstWrEn", scalfac_write_enable, 0);
    checkOutput("rstWrAddr", scalfac_write_addr, 0);
    checkOutput("rstWrData", scalfac_write_data, 0);
    checkOutput("rstSwitch", buffer_switch_event, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
  endtask

  // Replays the granule band by band: zero width costs 1 cycle, a read 2 + responder delay.
  task automatic verifyGranule(input int s1, input int s2, input int base,
                               input bit pendingMode, input int cdCyc);
    int cur;
    int ri;
    int w;
    int expData;
    int nReads;
    cur = base;
    ri = 0;
    nReads = 0;
    for (int b = 0; b < NB; b++) if (bandWidth(b, s1, s2) > 0) nReads++;
    checkOutput("numWrites", wrQ.size(), NB);
    checkOutput("numReads", rdQ.size(), nReads);
    checkOutput("numSwitches", swQ.size(), 1);
    for (int b = 0; b < NB && b < wrQ.size(); b++) begin
      w = bandWidth(b, s1, s2);
      if (w == 0) begin
        cur += 1;
        expData = 0;
      end else begin
        if (ri < rdQ.size()) begin
          checkOutput($sformatf("brLen[%0d]", b), rdQ[ri].len, w);
          checkOutput($sformatf("brLenStable[%0d]", b), rdQ[ri].stable, 1);
          cur += 2 + rdQ[ri].delay;
          expData = rdQ[ri].data % (1 << w);
        end else begin
          cur += 2;
          expData = 0;
        end
        ri++;
      end
      checkOutput($sformatf("wrAddr[%0d]", b), wrQ[b].addr, b);
      checkOutput($sformatf("wrData[%0d]", b), wrQ[b].data, expData);
      checkOutput($sformatf("wrCycle[%0d]", b), wrQ[b].cyc, cur);
    end
    if (swQ.size() > 0)
      checkOutput("switchCycle", swQ[0], pendingMode ? cur + 1 : cdCyc + 1);
  endtask

  task automatic applyStimulus(input int s1, input int s2, input bit withhold,
                               input bit earlyCd, input bit midStart);
    int base;
    int cdCyc;
    int budget;
    bit cdSent;
    bit startSent;
    wrQ.delete();
    rdQ.delete();
    swQ.delete();
    slen1 = 3'(s1);
    slen2 = 3'(s2);
    start = 1'b1;
    base  = cyc + 1;
    step();
    start = 1'b0;
    slen1 = 3'($urandom_range(0, 7));
    slen2 = 3'($urandom_range(0, 7));
    cdCyc = 0;
    cdSent = 1'b0;
    startSent = 1'b0;
    budget = 0;
    while (swQ.size() == 0 && budget < 3000) begin
      if (midStart && !startSent && wrQ.size() == 4) begin
        start = 1'b1;
        step();
        start = 1'b0;
        startSent = 1'b1;
      end else if (earlyCd && !cdSent && wrQ.size() == 5) begin
        consumer_done = 1'b1;
        step();
        consumer_done = 1'b0;
        cdSent = 1'b1;
      end else if (withhold && !cdSent && wrQ.size() == NB) begin
        repeat (5) step();
        checkOutput("busyInFilled", busy, 1);
        checkOutput("noEarlySwitch", swQ.size(), 0);
        consumer_done = 1'b1;
        cdCyc = cyc;
        step();
        consumer_done = 1'b0;
        cdSent = 1'b1;
      end else begin
        step();
      end
      budget++;
    end
    checkOutput("granuleTimeout", budget >= 3000, 0);
    step();
    checkOutput("idleAfterSwitch", busy, 0);
    verifyGranule(s1, s2, base, !withhold, cdCyc);
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int budget;
    bit wh;
    rst = 1'b0;
    repeat (3) step();
    checkResetOutputs();
    rst = 1'b1;
    step();

    applyStimulus(0, 0, 1'b0, 1'b0, 1'b0);

    fixedDelay = 1;
    fixedData  = 15;
    applyStimulus(4, 3, 1'b0, 1'b1, 1'b0);
    fixedDelay = -1;
    fixedData  = -1;

    applyStimulus($urandom_range(0, 7), $urandom_range(0, 7), 1'b1, 1'b0, 1'b0);

    longBand  = 3;
    longDelay = 7;
    applyStimulus($urandom_range(1, 4), $urandom_range(0, 7), 1'b0, 1'b1, 1'b1);
    longBand  = -1;

    // Abort a granule while band 9 is waiting on the bit reader.
    wrQ.delete();
    rdQ.delete();
    swQ.delete();
    slen1 = 3'd2;
    slen2 = 3'd2;
    longBand  = 9;
    longDelay = 40;
    start = 1'b1;
    step();
    start = 1'b0;
    budget = 0;
    while (!(wrQ.size() == 9 && br_req === 1'b1) && budget < 500) begin
      step();
      budget++;
    end
    checkOutput("reachBand9Wait", budget < 500, 1);
    rst = 1'b0;
    step();
    checkResetOutputs();
    rst = 1'b1;
    repeat (10) step();
    checkOutput("noWriteAfterAbort", wrQ.size(), 9);
    checkOutput("noSwitchAfterAbort", swQ.size(), 0);
    longBand = -1;
    applyStimulus($urandom_range(0, 7), $urandom_range(0, 7), 1'b0, 1'b0, 1'b0);

    noiseEn = 1'b1;
    for (int g = 0; g < 6; g++) begin
      wh = 1'($urandom_range(0, 1));
      applyStimulus($urandom_range(0, 7), $urandom_range(0, 7), wh, !wh,
                    1'($urandom_range(0, 1)));
    end
    noiseEn = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
